// File: rtl/dds_serial_rx.sv
// ============================================================================
// dds_serial_rx : DDS serial-port write receiver with shadow/active registers
// Revision      : 1.0
// ============================================================================
`default_nettype none

module dds_serial_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        ten_MHz_ext_0,
  input  logic        reset_0,
  input  logic        SDIO_0,
  input  logic        SCLK_0,
  input  logic        CSB_0,
  input  logic        IO_UPDATE_0,
  input  logic        IO_RESET_0,
  output logic [31:0] cfr1_0,
  output logic [31:0] cfr2_0,
  output logic [31:0] cfr3_0,
  output logic [63:0] ramp_limit_0,
  output logic [63:0] ramp_step_0,
  output logic [31:0] ramp_rate_0,
  output logic        word_done_0,
  output logic        update_0,
  output logic [4:0]  last_addr_0,
  output logic [1:0]  err_0
);

  localparam int C_SDIO  = 0;
  localparam int C_SCLK  = 1;
  localparam int C_CSB   = 2;
  localparam int C_UPD   = 3;
  localparam int C_IORST = 4;

  localparam logic [4:0] C_A_CFR1  = 5'h00;
  localparam logic [4:0] C_A_CFR2  = 5'h01;
  localparam logic [4:0] C_A_CFR3  = 5'h02;
  localparam logic [4:0] C_A_LIMIT = 5'h0B;
  localparam logic [4:0] C_A_STEP  = 5'h0C;
  localparam logic [4:0] C_A_RATE  = 5'h0D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  logic       clk;
  logic       rst;
  logic [4:0] bus_w;
  logic [4:0] sync_q [SYNC_STAGES];
  logic       sclk_dly_q;
  logic       upd_dly_q;
  logic       sdio_s, sclk_s, csb_s, upd_s, iorst_s;
  logic       sclk_rise_w;

  assign clk   = ten_MHz_ext_0;
  assign rst   = reset_0;
  assign bus_w = {IO_RESET_0, IO_UPDATE_0, CSB_0, SCLK_0, SDIO_0};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sclk_dly_q <= 1'b0;
      upd_dly_q  <= 1'b0;
    end else begin
      sync_q[0] <= bus_w;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_dly_q <= sync_q[SYNC_STAGES-1][C_SCLK];
      upd_dly_q  <= sync_q[SYNC_STAGES-1][C_UPD];
    end
  end

  assign sdio_s      = sync_q[SYNC_STAGES-1][C_SDIO];
  assign sclk_s      = sync_q[SYNC_STAGES-1][C_SCLK];
  assign csb_s       = sync_q[SYNC_STAGES-1][C_CSB];
  assign upd_s       = sync_q[SYNC_STAGES-1][C_UPD];
  assign iorst_s     = sync_q[SYNC_STAGES-1][C_IORST];
  assign sclk_rise_w = sclk_s & ~sclk_dly_q;

  // Receive FSM and bit datapath
  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [63:0] shift_q, shift_d;
  logic [4:0]  addr_q, addr_d;
  logic        armed_q, armed_d;
  logic        ld_pend_q, ld_pend_d;
  logic [1:0]  err_q, err_d;

  logic [4:0]  instr_addr_w;
  logic        instr_rd_w;
  logic        addr_ok_w;
  logic [6:0]  data_last_w;

  // The instruction byte completes with the bit being sampled this cycle.
  assign instr_rd_w   = shift_q[6];
  assign instr_addr_w = {shift_q[3:0], sdio_s};

  always_comb begin
    addr_ok_w = 1'b0;
    case (instr_addr_w)
      C_A_CFR1, C_A_CFR2, C_A_CFR3,
      C_A_LIMIT, C_A_STEP, C_A_RATE: addr_ok_w = 1'b1;
      default:                       addr_ok_w = 1'b0;
    endcase
  end

  assign data_last_w = (addr_q == C_A_LIMIT || addr_q == C_A_STEP) ? 7'd63 : 7'd31;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      armed_q   <= 1'b0;
      ld_pend_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      armed_q   <= armed_d;
      ld_pend_q <= ld_pend_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    armed_d   = armed_q | csb_s;
    ld_pend_d = 1'b0;
    err_d     = err_q;

    // armed_q stays low after reset until CSB is seen high once.
    if (iorst_s) begin
      state_d = (csb_s || !armed_q) ? IDLE : INSTR;
      cnt_d   = '0;
    end else if (state_q != IDLE && csb_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (state_q != INSTR || cnt_q != 7'd0) err_d[1] = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!csb_s && armed_q) begin
            state_d = INSTR;
            cnt_d   = '0;
          end
        end
        INSTR: begin
          if (sclk_rise_w) begin
            shift_d = {shift_q[62:0], sdio_s};
            if (cnt_q == 7'd7) begin
              cnt_d = '0;
              if (!instr_rd_w && addr_ok_w) begin
                state_d = DATA;
                addr_d  = instr_addr_w;
              end else begin
                state_d  = DRAIN;
                err_d[0] = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        DATA: begin
          if (sclk_rise_w) begin
            shift_d = {shift_q[62:0], sdio_s};
            if (cnt_q == data_last_w) begin
              cnt_d     = '0;
              state_d   = INSTR;
              ld_pend_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        DRAIN: begin
          if (sclk_rise_w) begin
            if (cnt_q == 7'd31) begin
              cnt_d   = '0;
              state_d = INSTR;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shadow and active register banks
  logic [31:0] cfr1_sh_q, cfr1_sh_d, cfr1_act_q;
  logic [31:0] cfr2_sh_q, cfr2_sh_d, cfr2_act_q;
  logic [31:0] cfr3_sh_q, cfr3_sh_d, cfr3_act_q;
  logic [63:0] lim_sh_q,  lim_sh_d,  lim_act_q;
  logic [63:0] step_sh_q, step_sh_d, step_act_q;
  logic [31:0] rate_sh_q, rate_sh_d, rate_act_q;
  logic        word_done_q;
  logic [4:0]  last_addr_q;
  logic        upd_pend_q;
  logic        update_q;

  always_comb begin
    cfr1_sh_d = cfr1_sh_q;
    cfr2_sh_d = cfr2_sh_q;
    cfr3_sh_d = cfr3_sh_q;
    lim_sh_d  = lim_sh_q;
    step_sh_d = step_sh_q;
    rate_sh_d = rate_sh_q;
    if (ld_pend_q) begin
      case (addr_q)
        C_A_CFR1:  cfr1_sh_d = shift_q[31:0];
        C_A_CFR2:  cfr2_sh_d = shift_q[31:0];
        C_A_CFR3:  cfr3_sh_d = shift_q[31:0];
        C_A_LIMIT: lim_sh_d  = shift_q;
        C_A_STEP:  step_sh_d = shift_q;
        C_A_RATE:  rate_sh_d = shift_q[31:0];
        default:   ;
      endcase
    end
  end

  // Copying from the *_d shadows lets a same-cycle load reach the active bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfr1_sh_q   <= '0;
      cfr2_sh_q   <= '0;
      cfr3_sh_q   <= '0;
      lim_sh_q    <= '0;
      step_sh_q   <= '0;
      rate_sh_q   <= '0;
      cfr1_act_q  <= '0;
      cfr2_act_q  <= '0;
      cfr3_act_q  <= '0;
      lim_act_q   <= '0;
      step_act_q  <= '0;
      rate_act_q  <= '0;
      word_done_q <= 1'b0;
      last_addr_q <= '0;
      upd_pend_q  <= 1'b0;
      update_q    <= 1'b0;
    end else begin
      cfr1_sh_q   <= cfr1_sh_d;
      cfr2_sh_q   <= cfr2_sh_d;
      cfr3_sh_q   <= cfr3_sh_d;
      lim_sh_q    <= lim_sh_d;
      step_sh_q   <= step_sh_d;
      rate_sh_q   <= rate_sh_d;
      word_done_q <= ld_pend_q;
      if (ld_pend_q) last_addr_q <= addr_q;
      upd_pend_q  <= upd_s & ~upd_dly_q;
      update_q    <= upd_pend_q;
      if (upd_pend_q) begin
        cfr1_act_q <= cfr1_sh_d;
        cfr2_act_q <= cfr2_sh_d;
        cfr3_act_q <= cfr3_sh_d;
        lim_act_q  <= lim_sh_d;
        step_act_q <= step_sh_d;
        rate_act_q <= rate_sh_d;
      end
    end
  end

  assign cfr1_0       = cfr1_act_q;
  assign cfr2_0       = cfr2_act_q;
  assign cfr3_0       = cfr3_act_q;
  assign ramp_limit_0 = lim_act_q;
  assign ramp_step_0  = step_act_q;
  assign ramp_rate_0  = rate_act_q;
  assign word_done_0  = word_done_q;
  assign update_0     = update_q;
  assign last_addr_0  = last_addr_q;
  assign err_0        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dds_serial_rx.sv
// ============================================================================
// tb_dds_serial_rx : directed + randomized bench for dds_serial_rx
// Revision         : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dds_serial_rx;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic        rst_i, sdio_i, sclk_i, csb_i, upd_i, iorst_i;
  logic [31:0] cfr1_o, cfr2_o, cfr3_o, rate_o;
  logic [63:0] limit_o, step_o;
  logic        word_done_o, update_o;
  logic [4:0]  last_addr_o;
  logic [1:0]  err_o;

  dds_serial_rx #(.SYNC_STAGES(2)) dut (
    .ten_MHz_ext_0 (clk),
    .reset_0       (rst_i),
    .SDIO_0        (sdio_i),
    .SCLK_0        (sclk_i),
    .CSB_0         (csb_i),
    .IO_UPDATE_0   (upd_i),
    .IO_RESET_0    (iorst_i),
    .cfr1_0        (cfr1_o),
    .cfr2_0        (cfr2_o),
    .cfr3_0        (cfr3_o),
    .ramp_limit_0  (limit_o),
    .ramp_step_0   (step_o),
    .ramp_rate_0   (rate_o),
    .word_done_0   (word_done_o),
    .update_0      (update_o),
    .last_addr_0   (last_addr_o),
    .err_0         (err_o)
  );

  int n_checks = 0;
  int n_err    = 0;
  int wd_seen  = 0;
  int upd_seen = 0;
  int exp_wd   = 0;
  int exp_upd  = 0;

  // Reference model: register file indexed by address.
  logic [63:0] m_sh  [32];
  logic [63:0] m_act [32];
  logic [1:0]  exp_err;
  logic [4:0]  exp_last;
  logic [4:0]  valid_addrs [6] = '{5'h00, 5'h01, 5'h02, 5'h0B, 5'h0C, 5'h0D};

  always @(posedge clk) begin
    if (word_done_o === 1'b1) wd_seen++;
    if (update_o === 1'b1) upd_seen++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int wlen(input logic [4:0] a);
    return (a == 5'h0B || a == 5'h0C) ? 64 : 32;
  endfunction

  function automatic logic is_valid(input logic [4:0] a);
    for (int i = 0; i < 6; i++) if (valid_addrs[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " cfr1"},      {32'h0, cfr1_o}, m_act[5'h00]);
    chk({tag, " cfr2"},      {32'h0, cfr2_o}, m_act[5'h01]);
    chk({tag, " cfr3"},      {32'h0, cfr3_o}, m_act[5'h02]);
    chk({tag, " limit"},     limit_o,         m_act[5'h0B]);
    chk({tag, " step"},      step_o,          m_act[5'h0C]);
    chk({tag, " rate"},      {32'h0, rate_o}, m_act[5'h0D]);
    chk({tag, " err"},       64'(err_o),      64'(exp_err));
    chk({tag, " last_addr"}, 64'(last_addr_o), 64'(exp_last));
    chk({tag, " word_done"}, 64'(wd_seen),    64'(exp_wd));
    chk({tag, " update"},    64'(upd_seen),   64'(exp_upd));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    exp_err  = '0;
    exp_last = '0;
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    cyc(3);
    model_reset();
    check_all(tag);
    rst_i = 1'b0;
    cyc(2);
  endtask

  task automatic shift_out(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdio_i = v[i];
      cyc(2);
      sclk_i = 1'b1;
      cyc(3);
      sclk_i = 1'b0;
      cyc(1);
    end
  endtask

  task automatic frame_start();
    csb_i = 1'b0;
    cyc(4);
  endtask

  task automatic frame_end();
    cyc(4);
    csb_i = 1'b1;
    cyc(6);
  endtask

  task automatic write_word(input logic [4:0] a, input logic [63:0] d);
    shift_out({56'h0, 3'b000, a}, 8);
    shift_out(d, wlen(a));
    m_sh[a]  = (wlen(a) == 64) ? d : {32'h0, d[31:0]};
    exp_wd++;
    exp_last = a;
  endtask

  task automatic bad_instr(input logic [7:0] ins, input logic [31:0] junk);
    shift_out({56'h0, ins}, 8);
    shift_out({32'h0, junk}, 32);
    exp_err[0] = 1'b1;
  endtask

  task automatic do_update();
    upd_i = 1'b1;
    cyc(4);
    upd_i = 1'b0;
    cyc(6);
    for (int i = 0; i < 32; i++) m_act[i] = m_sh[i];
    exp_upd++;
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  ins;
    int          nw;

    rst_i = 1'b1; sdio_i = 1'b0; sclk_i = 1'b0; csb_i = 1'b1;
    upd_i = 1'b0; iorst_i = 1'b0;
    model_reset();
    cyc(2);
    do_reset("reset");

    // Single 0x0D write; active register must wait for IO_UPDATE.
    frame_start();
    write_word(5'h0D, 64'h12345678);
    frame_end();
    check_all("rate_pre_update");
    do_update();
    check_all("rate_post_update");

    // Streamed 184-bit frame under one CSB.
    frame_start();
    write_word(5'h0B, 64'h0000_1000_0000_0100);
    write_word(5'h0C, 64'h0000_0010_0000_0010);
    write_word(5'h0D, 64'h0001_0001);
    frame_end();
    do_update();
    check_all("burst184");

    // Read instruction drained, followed by a valid write in the same frame.
    frame_start();
    bad_instr(8'h85, 32'hA5A5_5A5A);
    write_word(5'h01, 64'h0040_0820);
    frame_end();
    do_update();
    check_all("read_then_write");

    // CSB raised after 20 data bits of a 0x00 write.
    frame_start();
    shift_out(64'h00, 8);
    shift_out(64'hDEADBEEF, 20);
    frame_end();
    exp_err[1] = 1'b1;
    do_update();
    check_all("abort");

    do_reset("reset2");

    // IO_RESET after 12 data bits, then a complete 0x02 write.
    frame_start();
    shift_out(64'h02, 8);
    shift_out(64'hABC, 12);
    iorst_i = 1'b1;
    cyc(4);
    iorst_i = 1'b0;
    cyc(4);
    write_word(5'h02, 64'h1F3F_C000);
    frame_end();
    do_update();
    check_all("io_reset");

    // IO_UPDATE rising together with the final SCLK edge of a 0x0C write.
    d = {$urandom, $urandom};
    frame_start();
    shift_out(64'h0C, 8);
    shift_out(d >> 1, 63);
    check_all("coincide_pre");
    sdio_i = d[0];
    cyc(2);
    sclk_i = 1'b1;
    upd_i  = 1'b1;
    cyc(3);
    sclk_i = 1'b0;
    cyc(4);
    upd_i  = 1'b0;
    m_sh[5'h0C] = d;
    exp_wd++;
    exp_last = 5'h0C;
    for (int i = 0; i < 32; i++) m_act[i] = m_sh[i];
    exp_upd++;
    check_all("coincide");
    frame_end();

    // Randomized frames of valid writes mixed with rejected instructions.
    for (int it = 0; it < 6; it++) begin
      frame_start();
      nw = int'($urandom_range(1, 3));
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          ins = 8'($urandom);
          if (!ins[7] && is_valid(ins[4:0])) ins[7] = 1'b1;
          bad_instr(ins, $urandom);
        end else begin
          write_word(valid_addrs[$urandom_range(0, 5)], {$urandom, $urandom});
        end
      end
      frame_end();
      check_all("rand_pre");
      do_update();
      check_all("rand_post");
    end

    // Reset mid-frame: bits sent before CSB returns high must be ignored.
    frame_start();
    shift_out(64'h0D, 8);
    shift_out(64'h3FF, 10);
    rst_i = 1'b1;
    cyc(3);
    rst_i = 1'b0;
    model_reset();
    cyc(2);
    shift_out(64'h0D, 8);
    shift_out(64'hCAFE_F00D, 32);
    check_all("post_reset_ignored");
    frame_end();
    frame_start();
    write_word(5'h0D, 64'h0BAD_BEEF);
    frame_end();
    do_update();
    check_all("post_reset_resume");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dds_serial_rx.md
DDS_SERIAL_RX -- requirements
Module: dds_serial_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (2..3).
REQ-002 SHALL have port ten_MHz_ext_0  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port reset_0  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports SDIO_0, SCLK_0, CSB_0, IO_UPDATE_0, IO_RESET_0  input  1 each  DDS serial bus, asynchronous to ten_MHz_ext_0.
REQ-005 SHALL have ports cfr1_0, cfr2_0, cfr3_0  output  32  active regs at addr 0x00/0x01/0x02.
REQ-006 SHALL have ports ramp_limit_0, ramp_step_0  output  64  active regs at addr 0x0B/0x0C; ramp_rate_0  output  32  active reg at addr 0x0D.
REQ-007 SHALL have port word_done_0  output  1  one-cycle pulse per completed register write.
REQ-008 SHALL have port update_0  output  1  one-cycle pulse when shadows are copied to active.
REQ-009 SHALL have port last_addr_0  output  5  address of the last completed write.
REQ-010 SHALL have port err_0  output  2  sticky flags: bit0 read/bad-address instruction, bit1 aborted frame.

Function
REQ-011 SHALL pass all five bus inputs through SYNC_STAGES flops, then detect edges against one extra delayed copy.
REQ-012 SHALL sample SDIO_0 only on a detected SCLK_0 rising edge while synchronized CSB_0 is low; SCLK_0 high and low phases SHALL each be ≥1 clock.
REQ-013 SHALL use states IDLE, INSTR, DATA, DRAIN.
REQ-014 IDLE -> INSTR when synchronized CSB_0 is low; bit counter cleared.
REQ-015 INSTR SHALL shift 8 bits MSB first: bit7 R/W (0 = write), bits6:5 ignored, bits4:0 address.
REQ-016 After the 8th bit: write with address in {00,01,02,0B,0C,0D} -> DATA; otherwise -> DRAIN and set err_0[0].
REQ-017 Data length SHALL be 64 bits for 0x0B/0x0C and 32 bits otherwise; DRAIN SHALL consume 32 bits and discard them.
REQ-018 DATA SHALL shift MSB first into a 64-bit shift register; after the last bit, the shadow register for that address SHALL load the next cycle, word_done_0 SHALL pulse, and last_addr_0 SHALL update.
REQ-019 After DATA or DRAIN completes, the FSM SHALL return to INSTR without CSB_0 going high, so streamed multi-instruction frames work (e.g. 184-bit 0x0B/0x0C/0x0D burst).
REQ-020 CSB_0 going high mid-INSTR/DATA/DRAIN SHALL abort: discard the partial word, set err_0[1], go to IDLE; at a word boundary, CSB_0 high is not an error.
REQ-021 Synchronized IO_RESET_0 high SHALL force INSTR (or IDLE if CSB_0 is high) with the counter cleared and the partial word discarded; it SHALL NOT set err_0 and SHALL NOT alter shadows or active registers.
REQ-022 A rising edge on synchronized IO_UPDATE_0 SHALL copy all six shadows to active registers one cycle later and pulse update_0; the level SHALL be ignored.
REQ-023 If a shadow load and the IO_UPDATE copy fall in the same cycle, the active register SHALL receive the newly loaded value.
REQ-024 Active registers SHALL change only on update_0 or reset.
REQ-025 Register addressing and width are fixed; no readback is driven on SDIO_0.

Reset
REQ-026 With reset_0 high at a posedge, the following SHALL hold at the next cycle:
  - FSM in IDLE, counters 0, synchronizers 0
  - all shadow and active registers 0
  - word_done_0 = 0, update_0 = 0, last_addr_0 = 0, err_0 = 0
REQ-027 Reset mid-frame SHALL discard the frame; after release, reception SHALL resume only after CSB_0 has been seen high and then low again.

Verification
REQ-028 Write 0x0D then 32'h12345678 with CSB_0 low, then pulse IO_UPDATE_0 -> word_done_0 pulses once, last_addr_0 = 0x0D, ramp_rate_0 = 32'h12345678 only after update_0.
REQ-029 Single 184-bit frame {0x0B, 64'h0000_1000_0000_0100, 0x0C, 64'h0000_0010_0000_0010, 0x0D, 32'h0001_0001} -> three word_done_0 pulses, err_0 = 0, all three active registers correct after IO_UPDATE_0.
REQ-030 Instruction 0x85 (read) followed by 32 bits, then a write of 0x01 = 32'h00400820 -> err_0[0] = 1, cfr2_0 = 32'h00400820 after update.
REQ-031 CSB_0 raised after 20 data bits of a 0x00 write -> err_0[1] = 1, no word_done_0, cfr1_0 unchanged.
REQ-032 IO_RESET_0 pulsed after 12 data bits, then a full 0x02 write of 32'h1F3FC000 -> cfr3_0 = 32'h1F3FC000 after update, err_0 = 0.
REQ-033 IO_UPDATE_0 edge arriving in the same cycle as the final-bit shadow load of 0x0C -> ramp_step_0 takes the new value.
